// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared state, command and digit-count definitions for the 7-seg controller
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } seg7_state_t;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  localparam int N_DIGITS = 8;

endpackage

// File: rtl/bcd_counter8.sv
// rtl/bcd_counter8.sv - 8-digit packed BCD counter with clear, increment and wrap carry-out
module bcd_counter8
  import seg7_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [31:0] count,
  output logic        carry
);

  logic [31:0]         nxt;
  logic [N_DIGITS:0]   c;

  // c[i] is the carry into digit i; a digit rolls 9->0 and passes the carry up
  always_comb begin
    nxt  = count;
    c    = '0;
    c[0] = inc;
    for (int i = 0; i < N_DIGITS; i++) begin
      c[i+1] = c[i] && (count[4*i +: 4] == 4'd9);
      if (c[i]) begin
        nxt[4*i +: 4] = (count[4*i +: 4] == 4'd9) ? 4'd0 : count[4*i +: 4] + 4'd1;
      end
    end
    if (clr) begin
      nxt = '0;
    end
  end

  assign carry = c[N_DIGITS] && !clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      count <= nxt;
    end
  end

endmodule

// File: rtl/seg7_display_controller.sv
// rtl/seg7_display_controller.sv - command FSM, BCD event counter and multiplexed digit scan
module seg7_display_controller
  import seg7_pkg::*;
#(
  parameter int TICK_DIV = 1,
  parameter int SCAN_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_7seg,
  input  logic [31:0] activation,
  output logic [31:0] count_bcd,
  output logic [2:0]  status,
  output logic [3:0]  digit,
  output logic [7:0]  AN
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(N_DIGITS);

  seg7_state_t   state, state_nxt;
  logic          ovf;
  logic [TW-1:0] pre;
  logic [SW-1:0] scan;
  logic [IW-1:0] idx, msd;
  logic [31:0]   cnt;
  logic [1:0]    cmd;
  logic          cmd_valid, is_start, is_clear, tick, clr, carry;
  logic          unused_activation;

  assign cmd               = activation[1:0];
  assign unused_activation = ^activation[31:2];
  assign cmd_valid         = we_7seg && (cmd != CMD_NOP);
  assign is_start          = we_7seg && (cmd == CMD_START);
  assign is_clear          = we_7seg && (cmd == CMD_CLEAR);
  assign clr               = is_start || is_clear;
  // any command on this edge takes priority over the pending increment
  assign tick = (state == COUNT) && (pre == TW'(TICK_DIV - 1)) && !cmd_valid;

  bcd_counter8 u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .inc   (tick),
    .count (cnt),
    .carry (carry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    case (state)
      IDLE, COUNT, HOLD: state_nxt = state;
      default:           state_nxt = IDLE;
    endcase
    if (we_7seg) begin
      case (cmd)
        CMD_START: state_nxt = COUNT;
        CMD_STOP:  if (state == COUNT) state_nxt = HOLD;
        CMD_CLEAR: state_nxt = IDLE;
        default:   ;
      endcase
    end
  end

  always_comb begin
    status = {ovf, state};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf  <= 1'b0;
      pre  <= '0;
      scan <= '0;
      idx  <= '0;
    end else begin
      if (clr) begin
        ovf <= 1'b0;
      end else if (carry) begin
        ovf <= 1'b1;
      end
      if (is_start || state != COUNT || pre == TW'(TICK_DIV - 1)) begin
        pre <= '0;
      end else begin
        pre <= pre + TW'(1);
      end
      if (scan == SW'(SCAN_DIV - 1)) begin
        scan <= '0;
        idx  <= idx + IW'(1);
      end else begin
        scan <= scan + SW'(1);
      end
    end
  end

  // highest nonzero digit; digits above it are blanked, digit 0 always shown
  always_comb begin
    msd = '0;
    for (int i = 1; i < N_DIGITS; i++) begin
      if (cnt[4*i +: 4] != 4'd0) begin
        msd = IW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      AN    <= 8'hFF;
      digit <= 4'd0;
    end else if (idx > msd) begin
      AN    <= 8'hFF;
      digit <= 4'd0;
    end else begin
      AN    <= ~(8'(1) << idx);
      digit <= cnt[{idx, 2'b00} +: 4];
    end
  end

  assign count_bcd = cnt;

endmodule

// File: tb/tb_seg7_display_controller.sv
// tb/tb_seg7_display_controller.sv - randomized bench for seg7_display_controller with a decimal reference model
module tb_seg7_display_controller;

  localparam int SCAN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [31:0] act = '0;
  logic [31:0] c1, c3;
  logic [2:0]  s1, s3;
  logic [3:0]  d1, d3;
  logic [7:0]  an1, an3;

  int vectors = 0;
  int miscompares = 0;

  int          m_val [2];
  bit          m_ovf [2];
  int          m_st  [2];
  int          m_age [2];
  logic [7:0]  m_an  [2];
  logic [3:0]  m_dig [2];
  int          tdiv  [2] = '{1, 3};
  int          m_scan, m_idx;
  int          base;
  bit          tick, cmdv;
  bit          skip_cmp = 1'b0;
  bit          preload_req = 1'b0;
  int          preload_val = 0;
  logic [31:0] pv_bcd = '0;
  int          r;

  always #5 clk = ~clk;

  seg7_display_controller #(.TICK_DIV(1), .SCAN_DIV(SCAN)) dut1 (
    .clk(clk), .rst(rst), .we_7seg(we), .activation(act),
    .count_bcd(c1), .status(s1), .digit(d1), .AN(an1)
  );

  seg7_display_controller #(.TICK_DIV(3), .SCAN_DIV(SCAN)) dut3 (
    .clk(clk), .rst(rst), .we_7seg(we), .activation(act),
    .count_bcd(c3), .status(s3), .digit(d3), .AN(an3)
  );

  function automatic logic [31:0] to_bcd(int v);
    logic [31:0] res;
    int t;
    t = v;
    for (int i = 0; i < 8; i++) begin
      res[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return res;
  endfunction

  function automatic int ndigits(int v);
    int n, t;
    n = 1;
    t = v;
    while (t >= 10) begin
      t = t / 10;
      n++;
    end
    return n;
  endfunction

  function automatic int pow10(int e);
    int p;
    p = 1;
    repeat (e) p = p * 10;
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // decimal reference: value as an integer, display derived from its decimal digits
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int i = 0; i < 2; i++) begin
          m_val[i] = 0; m_ovf[i] = 0; m_st[i] = 0; m_age[i] = 0;
          m_an[i] = 8'hFF; m_dig[i] = 4'd0;
        end
        m_scan = 0;
        m_idx = 0;
      end else begin
        cmdv = we && (act[1:0] != 2'b00);
        for (int i = 0; i < 2; i++) begin
          base = preload_req ? preload_val : m_val[i];
          if (m_idx < ndigits(base)) begin
            m_an[i]  = ~(8'h01 << m_idx);
            m_dig[i] = 4'((base / pow10(m_idx)) % 10);
          end else begin
            m_an[i]  = 8'hFF;
            m_dig[i] = 4'd0;
          end
          m_age[i] = m_age[i] + 1;
          tick = (m_st[i] == 1) && (m_age[i] % tdiv[i] == 0);
          m_val[i] = base;
          if (cmdv) begin
            case (act[1:0])
              2'b01: begin m_val[i] = 0; m_ovf[i] = 0; m_st[i] = 1; m_age[i] = 0; end
              2'b10: if (m_st[i] == 1) m_st[i] = 2;
              default: begin m_val[i] = 0; m_ovf[i] = 0; m_st[i] = 0; end
            endcase
          end else if (tick) begin
            if (base == 99999999) begin
              m_val[i] = 0;
              m_ovf[i] = 1;
            end else begin
              m_val[i] = base + 1;
            end
          end
        end
        if (m_scan == SCAN - 1) begin
          m_scan = 0;
          m_idx = (m_idx + 1) % 8;
        end else begin
          m_scan++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!skip_cmp) begin
        chk("cnt1", c1, to_bcd(m_val[0]));
        chk("st1", {29'd0, s1}, {29'd0, m_ovf[0], 2'(m_st[0])});
        chk("an1", {24'd0, an1}, {24'd0, m_an[0]});
        chk("dig1", {28'd0, d1}, {28'd0, m_dig[0]});
        chk("cnt3", c3, to_bcd(m_val[1]));
        chk("st3", {29'd0, s3}, {29'd0, m_ovf[1], 2'(m_st[1])});
        chk("an3", {24'd0, an3}, {24'd0, m_an[1]});
        chk("dig3", {28'd0, d3}, {28'd0, m_dig[1]});
      end
    end
  end

  task automatic cmd(input logic [1:0] c);
    we = 1'b1;
    act = ($urandom & 32'hFFFF_FFFC) | {30'd0, c};
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic preload(input int v);
    skip_cmp = 1'b1;
    preload_val = v;
    pv_bcd = to_bcd(v);
    force dut1.u_cnt.count = pv_bcd;
    force dut3.u_cnt.count = pv_bcd;
    #2;
    release dut1.u_cnt.count;
    release dut3.u_cnt.count;
    preload_req = 1'b1;
    @(negedge clk);
    preload_req = 1'b0;
    skip_cmp = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_an", {24'd0, an1}, 32'hFF);
    chk("rst_cnt", c1, 32'h0);
    chk("rst_st", {29'd0, s1}, 32'h0);
    rst = 1'b1;
    #1;
    chk("rel_an", {24'd0, an1}, 32'hFF);
    @(negedge clk);
    #1;
    chk("first_sel", {24'd0, an1}, 32'hFE);
    chk("first_dig", {28'd0, d1}, 32'h0);
    repeat (20) @(negedge clk);

    cmd(2'b01);
    repeat (100) @(negedge clk);
    cmd(2'b10);
    #1;
    chk("held100", c1, 32'h00000100);
    chk("held_st", {29'd0, s1}, 32'h2);
    chk("held33", c3, 32'h00000033);
    repeat (30) @(negedge clk);
    #1;
    chk("still100", c1, 32'h00000100);

    cmd(2'b01);
    repeat (75) @(negedge clk);
    cmd(2'b10);
    #1;
    chk("held75", c1, 32'h00000075);
    chk("held25", c3, 32'h00000025);
    for (int n = 0; n < 40 && an1 !== 8'hFD; n++) @(negedge clk);
    chk("an_fd", {24'd0, an1}, 32'hFD);
    chk("dig_7", {28'd0, d1}, 32'h7);

    cmd(2'b01);
    repeat (9) @(negedge clk);
    cmd(2'b10);
    #1;
    chk("div3_10", c3, 32'h3);
    chk("div1_10", c1, 32'h9);
    cmd(2'b01);
    repeat (8) @(negedge clk);
    cmd(2'b10);
    #1;
    chk("div3_coinc", c3, 32'h2);
    chk("div1_9", c1, 32'h8);

    cmd(2'b01);
    repeat (20) @(negedge clk);
    cmd(2'b11);
    #1;
    chk("clr_st", {29'd0, s1}, 32'h0);
    chk("clr_cnt", c1, 32'h0);
    cmd(2'b10);
    #1;
    chk("stop_idle", {29'd0, s1}, 32'h0);
    cmd(2'b01);
    repeat (5) @(negedge clk);
    cmd(2'b01);
    repeat (3) @(negedge clk);
    cmd(2'b10);
    #1;
    chk("restart", c1, 32'h3);

    cmd(2'b01);
    repeat (2) @(negedge clk);
    preload(99999995);
    repeat (4) @(negedge clk);
    cmd(2'b10);
    #1;
    chk("wrap_cnt", c1, 32'h0);
    chk("wrap_st", {29'd0, s1}, 32'h6);
    repeat (5) @(negedge clk);
    #1;
    chk("ovf_sticky", {31'd0, s1[2]}, 32'h1);

    cmd(2'b01);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rstpulse_cnt", c1, 32'h0);
    chk("rstpulse_st", {29'd0, s1}, 32'h0);
    chk("rstpulse_an", {24'd0, an1}, 32'hFF);
    rst = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      r = int'($urandom_range(0, 199));
      we = 1'b0;
      act = $urandom;
      if (r < 14) begin
        we = 1'b1;
      end else if (r < 20) begin
        we = 1'b1;
        act[1:0] = 2'b01;
      end else if (r == 20) begin
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end else if (r == 21) begin
        preload(int'($urandom_range(99999900, 99999999)));
      end
    end
    @(negedge clk);
    we = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
